// File: rtl/alu_decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word into a
// 2-entry skid buffer that feeds the execute stage.
//
// state    | meaning
// ST_EMPTY | no bundle held, out_valid low
// ST_ONE   | head entry holds the presented bundle
// ST_TWO   | head and skid both full, in_ready low
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  alu_function,
    output logic [1:0]  op_a_sel,
    output logic        op_b_sel,
    output logic [31:0] imm,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [31:0] pc_out,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        is_branch,
    output logic        branch_invert,
    output logic        is_jump,
    output logic        illegal
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_SLL  = 5'd3;
    localparam logic [4:0] ALU_SRL  = 5'd4;
    localparam logic [4:0] ALU_SRA  = 5'd5;
    localparam logic [4:0] ALU_SEQ  = 5'd6;
    localparam logic [4:0] ALU_SLT  = 5'd7;
    localparam logic [4:0] ALU_SLTU = 5'd8;
    localparam logic [4:0] ALU_XOR  = 5'd9;
    localparam logic [4:0] ALU_OR   = 5'd10;
    localparam logic [4:0] ALU_AND  = 5'd11;

    localparam logic [1:0] SEL_A_RS1  = 2'd0;
    localparam logic [1:0] SEL_A_PC   = 2'd1;
    localparam logic [1:0] SEL_A_ZERO = 2'd2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [4:0]  alu;
        logic [1:0]  op_a;
        logic        op_b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_branch;
        logic        branch_invert;
        logic        is_jump;
        logic        illegal;
    } bundle_t;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [4:0]  alu_f3;
    logic        bad;
    logic        writes;
    bundle_t     dec;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'h000};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    // Shared funct3 map of OP and OP-IMM; funct7 refinements happen below.
    always_comb begin
        case (f3)
            3'b000:  alu_f3 = ALU_ADD;
            3'b001:  alu_f3 = ALU_SLL;
            3'b010:  alu_f3 = ALU_SLT;
            3'b011:  alu_f3 = ALU_SLTU;
            3'b100:  alu_f3 = ALU_XOR;
            3'b101:  alu_f3 = ALU_SRL;
            3'b110:  alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        dec     = '0;
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        dec.rd  = in_instr[11:7];
        dec.pc  = in_pc;
        bad     = 1'b0;
        writes  = 1'b0;
        case (opc)
            OPC_LUI: begin
                dec.op_a = SEL_A_ZERO;
                dec.op_b = 1'b1;
                dec.imm  = imm_u;
                dec.alu  = ALU_ADD;
                writes   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op_a = SEL_A_PC;
                dec.op_b = 1'b1;
                dec.imm  = imm_u;
                dec.alu  = ALU_ADD;
                writes   = 1'b1;
            end
            OPC_JAL: begin
                dec.op_a    = SEL_A_PC;
                dec.op_b    = 1'b1;
                dec.imm     = imm_j;
                dec.alu     = ALU_ADD;
                dec.is_jump = 1'b1;
                writes      = 1'b1;
            end
            OPC_JALR: begin
                dec.op_b    = 1'b1;
                dec.imm     = imm_i;
                dec.alu     = ALU_ADD;
                dec.is_jump = 1'b1;
                writes      = 1'b1;
                bad         = (f3 != 3'b000);
            end
            OPC_LOAD: begin
                dec.op_b     = 1'b1;
                dec.imm      = imm_i;
                dec.alu      = ALU_ADD;
                dec.mem_read = 1'b1;
                writes       = 1'b1;
                bad          = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec.op_b      = 1'b1;
                dec.imm       = imm_s;
                dec.alu       = ALU_ADD;
                dec.mem_write = 1'b1;
                bad           = f3[2] || (f3 == 3'b011);
            end
            OPC_BRANCH: begin
                dec.imm           = imm_b;
                dec.is_branch     = 1'b1;
                dec.branch_invert = f3[0];
                case (f3[2:1])
                    2'b00:   dec.alu = ALU_SEQ;
                    2'b10:   dec.alu = ALU_SLT;
                    2'b11:   dec.alu = ALU_SLTU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec.op_b = 1'b1;
                dec.imm  = imm_i;
                dec.alu  = alu_f3;
                writes   = 1'b1;
                if (f3 == 3'b001) begin
                    bad = (f7 != F7_BASE);
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_ALT) dec.alu = ALU_SRA;
                    else bad = (f7 != F7_BASE);
                end
            end
            OPC_OP: begin
                dec.alu = alu_f3;
                writes  = 1'b1;
                if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      dec.alu = ALU_SUB;
                    else if (f3 == 3'b101) dec.alu = ALU_SRA;
                    else                   bad = 1'b1;
                end else if (f7 != F7_BASE) begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        dec.reg_write = writes && (dec.rd != 5'd0);
        // Illegal words still travel down the pipe, but inert.
        if (bad) begin
            dec.alu           = ALU_NONE;
            dec.op_a          = SEL_A_RS1;
            dec.op_b          = 1'b0;
            dec.imm           = '0;
            dec.reg_write     = 1'b0;
            dec.mem_read      = 1'b0;
            dec.mem_write     = 1'b0;
            dec.is_branch     = 1'b0;
            dec.branch_invert = 1'b0;
            dec.is_jump       = 1'b0;
            dec.illegal       = 1'b1;
        end
    end

    logic [1:0] state_q, state_d;
    logic       in_ready_q, in_ready_d;
    bundle_t    head_q, head_d;
    bundle_t    skid_q, skid_d;
    logic       in_xfer;
    logic       out_xfer;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = (state_q != ST_EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_ONE;
                        head_d  = dec;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_d = dec;
                    end else if (in_xfer) begin
                        state_d = ST_TWO;
                        skid_d  = dec;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_d = ST_ONE;
                        head_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = (state_q != ST_EMPTY);
    assign alu_function  = head_q.alu;
    assign op_a_sel      = head_q.op_a;
    assign op_b_sel      = head_q.op_b;
    assign imm           = head_q.imm;
    assign rs1_addr      = head_q.rs1;
    assign rs2_addr      = head_q.rs2;
    assign rd_addr       = head_q.rd;
    assign pc_out        = head_q.pc;
    assign reg_write     = head_q.reg_write;
    assign mem_read      = head_q.mem_read;
    assign mem_write     = head_q.mem_write;
    assign is_branch     = head_q.is_branch;
    assign branch_invert = head_q.branch_invert;
    assign is_jump       = head_q.is_jump;
    assign illegal       = head_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Testbench for alu_decode_stage: hand-computed decode vectors, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_function;
    logic [1:0]  op_a_sel;
    logic        op_b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] pc_out;
    logic        reg_write, mem_read, mem_write, is_branch, branch_invert, is_jump, illegal;

    alu_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_function(alu_function), .op_a_sel(op_a_sel),
        .op_b_sel(op_b_sel), .imm(imm), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .pc_out(pc_out), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .is_branch(is_branch), .branch_invert(branch_invert),
        .is_jump(is_jump), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  alu;
        logic [1:0]  opa;
        logic        opb;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc;
        logic [6:0]  flags;  // {reg_write, mem_read, mem_write, is_branch, branch_invert, is_jump, illegal}
    } bundle_t;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  alu;
        logic [1:0]  opa;
        logic        opb;
        logic [31:0] imm;
        logic [6:0]  flags;
    } vec_t;

    int      checks = 0;
    int      errors = 0;
    bundle_t q[$];
    bit      m_armed;
    vec_t    vecs[20];

    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        bundle_t     b;
        logic [4:0]  f3_alu [8];
        logic [31:0] sx_i, sx_s, sx_b, sx_u, sx_j;
        int          f3, f7;
        bit          legal, writes;
        f3_alu = '{5'd1, 5'd3, 5'd7, 5'd8, 5'd9, 5'd4, 5'd10, 5'd11};
        f3     = int'(w[14:12]);
        f7     = int'(w[31:25]);
        sx_i   = 32'($signed(w) >>> 20);
        sx_s   = (sx_i & ~32'h1F) | 32'(w[11:7]);
        sx_b   = (32'($signed(w) >>> 19) & 32'hFFFF_F000) | (32'(w[7]) << 11)
               | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        sx_u   = w & 32'hFFFF_F000;
        sx_j   = (32'($signed(w) >>> 11) & 32'hFFF0_0000) | (w & 32'h000F_F000)
               | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        b      = '0;
        b.rs1  = w[19:15];
        b.rs2  = w[24:20];
        b.rd   = w[11:7];
        b.pc   = pc;
        legal  = 1'b1;
        writes = 1'b0;
        b.alu  = 5'd1;
        if (w[6:0] == 7'h37) begin
            b.opa = 2; b.opb = 1; b.imm = sx_u; writes = 1;
        end else if (w[6:0] == 7'h17) begin
            b.opa = 1; b.opb = 1; b.imm = sx_u; writes = 1;
        end else if (w[6:0] == 7'h6F) begin
            b.opa = 1; b.opb = 1; b.imm = sx_j; writes = 1; b.flags[1] = 1;
        end else if (w[6:0] == 7'h67) begin
            b.opb = 1; b.imm = sx_i; writes = 1; b.flags[1] = 1; legal = (f3 == 0);
        end else if (w[6:0] == 7'h03) begin
            b.opb = 1; b.imm = sx_i; writes = 1; b.flags[5] = 1;
            legal = (f3 inside {0, 1, 2, 4, 5});
        end else if (w[6:0] == 7'h23) begin
            b.opb = 1; b.imm = sx_s; b.flags[4] = 1; legal = (f3 <= 2);
        end else if (w[6:0] == 7'h63) begin
            b.imm = sx_b; b.flags[3] = 1; b.flags[2] = f3[0];
            if (f3 < 2)       b.alu = 5'd6;
            else if (f3 < 4)  legal = 0;
            else if (f3 < 6)  b.alu = 5'd7;
            else              b.alu = 5'd8;
        end else if (w[6:0] == 7'h13) begin
            b.opb = 1; b.imm = sx_i; writes = 1; b.alu = f3_alu[f3];
            if (f3 == 1) legal = (f7 == 0);
            if (f3 == 5) begin
                if (f7 == 32) b.alu = 5'd5;
                else legal = (f7 == 0);
            end
        end else if (w[6:0] == 7'h33) begin
            writes = 1; b.alu = f3_alu[f3];
            if (f7 == 32 && f3 == 0)      b.alu = 5'd2;
            else if (f7 == 32 && f3 == 5) b.alu = 5'd5;
            else if (f7 != 0)             legal = 0;
        end else begin
            legal = 0;
        end
        b.flags[6] = writes && (b.rd != 0);
        if (!legal) begin
            b.alu   = 5'd0;
            b.opa   = 0;
            b.opb   = 0;
            b.imm   = 0;
            b.flags = 7'b0000001;
        end
        return b;
    endfunction

    // Operand selects and immediate carry no meaning for an illegal bundle.
    function automatic bundle_t mask_ill(input bundle_t b, input bit ill);
        bundle_t r;
        r = b;
        if (ill) begin
            r.opa = 0;
            r.opb = 0;
            r.imm = 0;
        end
        return r;
    endfunction

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b.alu   = alu_function;
        b.opa   = op_a_sel;
        b.opb   = op_b_sel;
        b.imm   = imm;
        b.rs1   = rs1_addr;
        b.rs2   = rs2_addr;
        b.rd    = rd_addr;
        b.pc    = pc_out;
        b.flags = {reg_write, mem_read, mem_write, is_branch, branch_invert, is_jump, illegal};
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        bundle_t act, exp;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(m_armed && q.size() < 2));
        if (q.size() > 0) begin
            exp = mask_ill(q[0], q[0].flags[0]);
            act = mask_ill(dut_bundle(), q[0].flags[0]);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s_bundle: got %h expected %h at %0t", tag, act, exp, $time);
            end
        end
    endtask

    // Drive one cycle, advance the model at the edge, check at the falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic ordy, input logic fl, input string tag);
        bit in_x, out_x;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = p;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        in_x  = v && m_armed && (q.size() < 2);
        out_x = ordy && (q.size() > 0);
        if (fl) begin
            q.delete();
        end else begin
            if (out_x) void'(q.pop_front());
            if (in_x) q.push_back(ref_decode(ins, p));
        end
        m_armed = 1'b1;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        q.delete();
        m_armed   = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        checks++;
        if (dut_bundle() !== bundle_t'(0)) begin
            errors++;
            $display("FAIL rst_fields: got %h expected 0", dut_bundle());
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h6F;
            3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h03;
            5: w[6:0] = 7'h23;
            6: w[6:0] = 7'h63;
            7: w[6:0] = 7'h13;
            8: w[6:0] = 7'h33;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'b0000000;
            1: w[31:25] = 7'b0100000;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h00500093, 5'd1, 2'd0, 1'b1, 32'h00000005, 7'b1000000};
        vecs[1]  = '{32'h402081B3, 5'd2, 2'd0, 1'b0, 32'h00000000, 7'b1000000};
        vecs[2]  = '{32'h0020D463, 5'd7, 2'd0, 1'b0, 32'h00000008, 7'b0001100};
        vecs[3]  = '{32'hFFFFFFFF, 5'd0, 2'd0, 1'b0, 32'h00000000, 7'b0000001};
        vecs[4]  = '{32'h00100013, 5'd1, 2'd0, 1'b1, 32'h00000001, 7'b0000000};
        vecs[5]  = '{32'h123452B7, 5'd1, 2'd2, 1'b1, 32'h12345000, 7'b1000000};
        vecs[6]  = '{32'hFFFFF117, 5'd1, 2'd1, 1'b1, 32'hFFFFF000, 7'b1000000};
        vecs[7]  = '{32'hFFDFF0EF, 5'd1, 2'd1, 1'b1, 32'hFFFFFFFC, 7'b1000010};
        vecs[8]  = '{32'h00008067, 5'd1, 2'd0, 1'b1, 32'h00000000, 7'b0000010};
        vecs[9]  = '{32'hFF812303, 5'd1, 2'd0, 1'b1, 32'hFFFFFFF8, 7'b1100000};
        vecs[10] = '{32'h00712623, 5'd1, 2'd0, 1'b1, 32'h0000000C, 7'b0010000};
        vecs[11] = '{32'hFE20E8E3, 5'd8, 2'd0, 1'b0, 32'hFFFFFFF0, 7'b0001000};
        vecs[12] = '{32'h0020A463, 5'd0, 2'd0, 1'b0, 32'h00000000, 7'b0000001};
        vecs[13] = '{32'h40335293, 5'd5, 2'd0, 1'b1, 32'h00000403, 7'b1000000};
        vecs[14] = '{32'h40331293, 5'd0, 2'd0, 1'b0, 32'h00000000, 7'b0000001};
        vecs[15] = '{32'h403140B3, 5'd0, 2'd0, 1'b0, 32'h00000000, 7'b0000001};
        vecs[16] = '{32'h403150B3, 5'd5, 2'd0, 1'b0, 32'h00000000, 7'b1000000};
        vecs[17] = '{32'h023100B3, 5'd0, 2'd0, 1'b0, 32'h00000000, 7'b0000001};
        vecs[18] = '{32'h0000000F, 5'd0, 2'd0, 1'b0, 32'h00000000, 7'b0000001};
        vecs[19] = '{32'hFFF13093, 5'd8, 2'd0, 1'b1, 32'hFFFFFFFF, 7'b1000000};

        @(negedge clk);
        do_reset();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "post_rst");

        // Decode table, one instruction at a time through an empty buffer.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] pc_v;
            logic [31:0] w;
            pc_v = $urandom & 32'hFFFF_FFFC;
            w    = vecs[i].instr;
            step(1'b1, w, pc_v, 1'b1, 1'b0, "vec_load");
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_alu", i), 32'(alu_function), 32'(vecs[i].alu));
            chk($sformatf("vec%0d_flags", i),
                32'({reg_write, mem_read, mem_write, is_branch, branch_invert, is_jump, illegal}),
                32'(vecs[i].flags));
            chk($sformatf("vec%0d_regs", i), 32'({rs1_addr, rs2_addr, rd_addr}),
                32'({w[19:15], w[24:20], w[11:7]}));
            chk($sformatf("vec%0d_pc", i), pc_out, pc_v);
            if (!vecs[i].flags[0]) begin
                chk($sformatf("vec%0d_op_a", i), 32'(op_a_sel), 32'(vecs[i].opa));
                chk($sformatf("vec%0d_op_b", i), 32'(op_b_sel), 32'(vecs[i].opb));
                chk($sformatf("vec%0d_imm", i), imm, vecs[i].imm);
            end
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "vec_drain");
        end

        // Three back-to-back words while execute stalls.
        step(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0, "bp0");
        step(1'b1, 32'h402081B3, 32'h104, 1'b0, 1'b0, "bp1");
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head_pc0", pc_out, 32'h100);
        step(1'b1, 32'h0020D463, 32'h108, 1'b0, 1'b0, "bp_hold");
        step(1'b1, 32'h0020D463, 32'h108, 1'b0, 1'b0, "bp_hold");
        chk("bp_stable_pc0", pc_out, 32'h100);
        step(1'b1, 32'h0020D463, 32'h108, 1'b1, 1'b0, "bp_pop0");
        chk("bp_head_pc1", pc_out, 32'h104);
        step(1'b1, 32'h0020D463, 32'h108, 1'b1, 1'b0, "bp_pop1");
        chk("bp_head_pc2", pc_out, 32'h108);
        chk("bp_head_alu2", 32'(alu_function), 32'd7);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "bp_pop2");
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Flush while full, with a word offered in the same cycle.
        step(1'b1, 32'h00500093, 32'h200, 1'b0, 1'b0, "fl0");
        step(1'b1, 32'h00100013, 32'h204, 1'b0, 1'b0, "fl1");
        step(1'b1, 32'h123452B7, 32'h208, 1'b1, 1'b1, "fl_do");
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "fl_after");
        chk("flush_no_bundle", 32'(out_valid), 32'd0);

        // Reset pulse while one bundle is held.
        step(1'b1, 32'hFFDFF0EF, 32'h300, 1'b0, 1'b0, "rp_one");
        rst_n = 1'b0;
        #1;
        chk("rst_pulse_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pulse_in_ready", 32'(in_ready), 32'd0);
        q.delete();
        m_armed = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h00712623, 32'h304, 1'b1, 1'b0, "rp_first_edge");
        chk("rst_ready_first_edge", 32'(in_ready), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "rp_drain");

        // Random traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
